// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_stage_if : instruction-bus, redirect and decode-side signals of fetch
// Rev 1.0
// ============================================================================
interface fetch_stage_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_data_ok, iresp_data,
        input  redirect_valid, redirect_pc,
        input  out_ready,
        output out_valid, out_pc, out_instr, out_exc
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_data_ok, iresp_data,
        output redirect_valid, redirect_pc,
        output out_ready,
        input  out_valid, out_pc, out_instr, out_exc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : single-outstanding instruction fetch with redirect and a
//               one-entry output register. Option: FETCH_MISALIGN_EXC_EN.
// Rev 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  wire            clk,
    input  wire            reset,
    fetch_stage_if.master  bus
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_FETCH   = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [63:0] r_pc;
    logic [63:0] r_req_addr;
    logic        r_out_valid;
    logic [63:0] r_out_pc;
    logic [31:0] r_out_instr;

    logic        w_slot_free;
    logic        w_misaligned;
    logic        w_blocked;
    logic        w_start;
    logic        w_load;
    logic        w_exc_load;
    logic [63:0] w_req_addr_next;
    logic        w_ireq_valid;

    assign w_slot_free = !r_out_valid || bus.out_ready;

`ifdef FETCH_MISALIGN_EXC_EN
    logic r_out_exc;
    logic r_exc_hold;

    // After a misalign fault is reported, fetch stays parked until redirected.
    assign w_misaligned    = (r_pc[1:0] != 2'b00);
    assign w_blocked       = r_exc_hold;
    assign w_req_addr_next = r_pc;
`else
    assign w_misaligned    = 1'b0;
    assign w_blocked       = 1'b0;
    assign w_req_addr_next = {r_pc[63:2], 2'b00};
`endif

    assign w_start    = (r_state == c_IDLE) && w_slot_free && !bus.redirect_valid
                        && !w_misaligned && !w_blocked;
    assign w_exc_load = (r_state == c_IDLE) && w_slot_free && !bus.redirect_valid
                        && w_misaligned && !w_blocked;
    assign w_load     = (r_state == c_FETCH) && bus.iresp_data_ok && !bus.redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_next_state = c_FETCH;
                end
            end
            c_FETCH: begin
                // A redirect without a response must still drain the old request.
                if (bus.redirect_valid) begin
                    w_next_state = bus.iresp_data_ok ? c_IDLE : c_DISCARD;
                end else if (bus.iresp_data_ok) begin
                    w_next_state = c_IDLE;
                end
            end
            c_DISCARD: begin
                if (bus.iresp_data_ok) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_ireq_valid = 1'b0;
        case (r_state)
            c_FETCH, c_DISCARD: w_ireq_valid = 1'b1;
            default:            w_ireq_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc;
            end else if (w_load) begin
                r_pc <= r_pc + 64'd4;
            end
            if (w_start) begin
                r_req_addr <= w_req_addr_next;
            end
        end
    end

    // Redirect flushes the output register ahead of both consume and load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= 64'd0;
            r_out_instr <= 32'd0;
        end else if (bus.redirect_valid) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_req_addr;
            r_out_instr <= bus.iresp_data;
        end else if (w_exc_load) begin
            r_out_valid <= 1'b1;
            r_out_pc    <= r_pc;
            r_out_instr <= 32'd0;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef FETCH_MISALIGN_EXC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_exc  <= 1'b0;
            r_exc_hold <= 1'b0;
        end else begin
            if (bus.redirect_valid) begin
                r_exc_hold <= 1'b0;
            end else if (w_exc_load) begin
                r_exc_hold <= 1'b1;
            end
            if (!bus.redirect_valid && w_load) begin
                r_out_exc <= 1'b0;
            end else if (w_exc_load) begin
                r_out_exc <= 1'b1;
            end
        end
    end

    assign bus.out_exc = r_out_exc;
`else
    assign bus.out_exc = 1'b0;
`endif

    assign bus.ireq_valid = w_ireq_valid;
    assign bus.ireq_addr  = r_req_addr;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_pc     = r_out_pc;
    assign bus.out_instr  = r_out_instr;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Rev 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [63:0] c_RESET_PC = 64'h0000_0000_8000_0000;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(c_RESET_PC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic respond(input logic ok, input logic [31:0] data);
        bus.iresp_data_ok = ok;
        bus.iresp_data    = data;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset              = 1'b1;
        bus.iresp_data_ok  = 1'b0;
        bus.iresp_data     = 32'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.out_ready      = 1'b1;
        tick();
        tick();
        check_val("rst_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
        check_val("rst_out_valid",  {63'd0, bus.out_valid},  64'd0);
        check_val("rst_out_pc",     bus.out_pc,              64'd0);
        check_val("rst_out_exc",    {63'd0, bus.out_exc},    64'd0);
        reset = 1'b0;

        // Two sequential fetches, response one cycle after each request.
        tick();
        check_val("f0_ireq_valid", {63'd0, bus.ireq_valid}, 64'd1);
        check_val("f0_ireq_addr",  bus.ireq_addr,           64'h8000_0000);
        respond(1'b1, 32'h0000_0013);
        tick();
        respond(1'b0, 32'd0);
        check_val("f0_out_valid", {63'd0, bus.out_valid}, 64'd1);
        check_val("f0_out_pc",    bus.out_pc,             64'h8000_0000);
        check_val("f0_out_instr", {32'd0, bus.out_instr}, 64'h0000_0013);
        check_val("f0_idle",      {63'd0, bus.ireq_valid}, 64'd0);
        tick();
        check_val("f1_ireq_addr",  bus.ireq_addr,           64'h8000_0004);
        check_val("f1_out_valid",  {63'd0, bus.out_valid},  64'd0);
        respond(1'b1, 32'h0010_0093);
        tick();
        respond(1'b0, 32'd0);
        check_val("f1_out_valid", {63'd0, bus.out_valid}, 64'd1);
        check_val("f1_out_pc",    bus.out_pc,             64'h8000_0004);
        check_val("f1_out_instr", {32'd0, bus.out_instr}, 64'h0010_0093);

        // Backpressure: no new request while the output slot is held.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
            check_val("bp_out_valid",  {63'd0, bus.out_valid},  64'd1);
            check_val("bp_out_pc",     bus.out_pc,              64'h8000_0004);
        end
        bus.out_ready = 1'b1;
        tick();
        check_val("bp_resume_valid", {63'd0, bus.ireq_valid}, 64'd1);
        check_val("bp_resume_addr",  bus.ireq_addr,           64'h8000_0008);
        check_val("bp_out_cleared",  {63'd0, bus.out_valid},  64'd0);

        // Redirect while waiting: old request held, its response dropped.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_1000;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_val("disc_ireq_valid", {63'd0, bus.ireq_valid}, 64'd1);
            check_val("disc_ireq_addr",  bus.ireq_addr,           64'h8000_0008);
            check_val("disc_out_valid",  {63'd0, bus.out_valid},  64'd0);
            tick();
        end
        respond(1'b1, 32'hBAD0_BAD0);
        tick();
        respond(1'b0, 32'd0);
        check_val("disc_drop_valid", {63'd0, bus.out_valid},  64'd0);
        check_val("disc_idle",       {63'd0, bus.ireq_valid}, 64'd0);
        tick();
        check_val("redir_ireq_addr", bus.ireq_addr,          64'h8000_1000);
        check_val("redir_out_valid", {63'd0, bus.out_valid}, 64'd0);

        // Redirect coinciding with data_ok: data dropped, refetch at new PC.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_2000;
        respond(1'b1, 32'hDEAD_BEEF);
        tick();
        bus.redirect_valid = 1'b0;
        respond(1'b0, 32'd0);
        check_val("same_out_valid",  {63'd0, bus.out_valid},  64'd0);
        check_val("same_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
        tick();
        check_val("same_ireq_addr", bus.ireq_addr, 64'h8000_2000);
        respond(1'b1, 32'h0000_0073);
        tick();
        respond(1'b0, 32'd0);
        check_val("same_out_pc",    bus.out_pc,             64'h8000_2000);
        check_val("same_out_instr", {32'd0, bus.out_instr}, 64'h0000_0073);
        check_val("same_out_exc",   {63'd0, bus.out_exc},   64'd0);

        // Misaligned redirect target.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0002;
        tick();
        bus.redirect_valid = 1'b0;
        check_val("mis_flush", {63'd0, bus.out_valid}, 64'd0);
        tick();
`ifdef FETCH_MISALIGN_EXC_EN
        check_val("mis_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
        check_val("mis_out_valid",  {63'd0, bus.out_valid},  64'd1);
        check_val("mis_out_exc",    {63'd0, bus.out_exc},    64'd1);
        check_val("mis_out_pc",     bus.out_pc,              64'h8000_0002);
        check_val("mis_out_instr",  {32'd0, bus.out_instr},  64'd0);
        tick();
        check_val("mis_consumed",   {63'd0, bus.out_valid},  64'd0);
        check_val("mis_park0",      {63'd0, bus.ireq_valid}, 64'd0);
        tick();
        check_val("mis_park1",      {63'd0, bus.ireq_valid}, 64'd0);
        check_val("mis_no_reload",  {63'd0, bus.out_valid},  64'd0);
`else
        check_val("mis_ireq_valid", {63'd0, bus.ireq_valid}, 64'd1);
        check_val("mis_ireq_addr",  bus.ireq_addr,           64'h8000_0000);
        respond(1'b1, 32'h0000_0013);
        tick();
        respond(1'b0, 32'd0);
        check_val("mis_out_pc",  bus.out_pc,           64'h8000_0000);
        check_val("mis_out_exc", {63'd0, bus.out_exc}, 64'd0);
`endif
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check_val("recov_ireq_valid", {63'd0, bus.ireq_valid}, 64'd1);
        check_val("recov_ireq_addr",  bus.ireq_addr,           64'h8000_0100);

        // Reset mid-request; a late response right after release is ignored.
        reset = 1'b1;
        #1;
        check_val("mid_rst_ireq", {63'd0, bus.ireq_valid}, 64'd0);
        tick();
        reset = 1'b0;
        respond(1'b1, 32'hFFFF_FFFF);
        tick();
        respond(1'b0, 32'd0);
        check_val("late_out_valid", {63'd0, bus.out_valid},  64'd0);
        check_val("late_ireq",      {63'd0, bus.ireq_valid}, 64'd1);
        check_val("late_ireq_addr", bus.ireq_addr,           c_RESET_PC);
        respond(1'b1, 32'h0000_0013);
        tick();
        respond(1'b0, 32'd0);
        check_val("post_rst_out_pc",    bus.out_pc,             c_RESET_PC);
        check_val("post_rst_out_instr", {32'd0, bus.out_instr}, 64'h0000_0013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
